// File: rtl/ap_lookup_arbiter.sv
// ap_lookup_arbiter: round-robin lookup arbiter with an in-order ID FIFO; AP_ARB_GRANT_CNT_EN adds grant_cnt
module ap_lookup_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int AP_WIDTH      = 16,
  parameter int ACTION_WIDTH  = 160,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ*AP_WIDTH-1:0]  req_ap,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [AP_WIDTH-1:0]          lkup_ap,
  output logic                         lkup_ap_vld,
  input  logic [ACTION_WIDTH-1:0]      lkup_action,
  input  logic                         lkup_action_vld,
  input  logic                         table_ready,
  input  logic                         table_wr_busy,
  output logic [ACTION_WIDTH-1:0]      resp_action,
  output logic [NUM_REQ-1:0]           resp_vld,
  output logic                         err_unexpected
`ifdef AP_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]        grant_cnt
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(ID_FIFO_DEPTH);
  typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] rr_ptr, win, idx, head;
  logic [IDW-1:0] id_fifo [ID_FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic found, xfer, pop, full, empty, live;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = id_fifo[rd_ptr[PW-1:0]];
  assign live  = state != INIT;
  assign pop   = lkup_action_vld && !empty && live;
  always_ff @(posedge clk) state <= reset ? INIT : state_nxt;
  always_comb begin
    state_nxt = (state == INIT) ? (table_ready ? RUN : INIT) : (table_wr_busy ? HOLD : RUN);
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_vld[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    xfer = found && state == RUN && !table_wr_busy && !full;
    req_rdy = xfer ? NUM_REQ'(1) << win : '0;
  end
  always_ff @(posedge clk)
    if (xfer) id_fifo[wr_ptr[PW-1:0]] <= win;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lkup_ap <= '0;
      lkup_ap_vld <= 1'b0;
      resp_action <= '0;
      resp_vld <= '0;
      err_unexpected <= 1'b0;
    end else begin
      lkup_ap_vld <= xfer;
      resp_vld <= pop ? NUM_REQ'(1) << head : '0;
      if (xfer) begin
        lkup_ap <= req_ap[win*AP_WIDTH +: AP_WIDTH];
        rr_ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        resp_action <= lkup_action;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (lkup_action_vld && empty && live) err_unexpected <= 1'b1;
    end
  end
`ifdef AP_ARB_GRANT_CNT_EN
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (reset) grant_cnt[i*16 +: 16] <= '0;
      else if (req_rdy[i] && req_vld[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_ap_lookup_arbiter.sv
// tb_ap_lookup_arbiter: directed scoreboard bench; the table model answers one cycle after lkup_ap_vld
`timescale 1ns/1ps
module tb_ap_lookup_arbiter;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int ACW = 160;
  typedef struct {
    logic [1:0]     id;
    logic [ACW-1:0] act;
    int             cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*AW-1:0] req_ap;
  logic [N-1:0] req_vld, req_rdy, resp_vld, rdy_s;
  logic [AW-1:0] lkup_ap, pa = '0;
  logic lkup_ap_vld, lkup_action_vld, table_ready, table_wr_busy, err_unexpected;
  logic tbl_vld = 1'b0, inj_vld = 1'b0, table_en = 1'b1, pv = 1'b0, lat_on = 1'b1;
  logic [ACW-1:0] lkup_action, resp_action, tbl_act = '0, inj_act = '0;
`ifdef AP_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, xfers = 0;
  int gs[5] = '{0, 1, 2, 3, 0};
  assign lkup_action_vld = tbl_vld | inj_vld;
  assign lkup_action = inj_vld ? inj_act : tbl_act;
  ap_lookup_arbiter dut (
    .clk(clk), .reset(reset), .req_ap(req_ap), .req_vld(req_vld), .req_rdy(req_rdy),
    .lkup_ap(lkup_ap), .lkup_ap_vld(lkup_ap_vld), .lkup_action(lkup_action),
    .lkup_action_vld(lkup_action_vld), .table_ready(table_ready), .table_wr_busy(table_wr_busy),
    .resp_action(resp_action), .resp_vld(resp_vld), .err_unexpected(err_unexpected)
`ifdef AP_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [ACW-1:0] act_of(input logic [AW-1:0] a);
    return {10{a ^ 16'h5A3C}};
  endfunction
  task automatic chk(input string tag, input logic [ACW-1:0] o, input logic [ACW-1:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  // Record the grant about to be taken at the coming edge, then move to the next negedge.
  task automatic tick;
    #1;
    rdy_s = req_rdy;
    if (!reset && |(req_vld & req_rdy)) begin
      xfers++;
      for (int i = 0; i < N; i++)
        if (req_rdy[i]) exp_q.push_back('{id: 2'(i), act: act_of(req_ap[i*AW +: AW]), cyc: lat_on ? cyc + 3 : -1});
    end
    @(negedge clk);
  endtask
  initial forever begin
    @(negedge clk);
    tbl_vld = table_en & pv;
    tbl_act = act_of(pa);
    pv = lkup_ap_vld;
    pa = lkup_ap;
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_vld !== '0) begin
        if (exp_q.size() == 0) chk("resp_spurious", ACW'(resp_vld), '0);
        else begin
          e = exp_q.pop_front();
          chk("resp_vld", ACW'(resp_vld), ACW'(4'(1) << e.id));
          chk("resp_action", resp_action, e.act);
          if (e.cyc >= 0) chk("resp_latency", ACW'(cyc), ACW'(e.cyc));
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    req_ap = {16'h13, 16'h12, 16'h11, 16'h10};
    req_vld = '0;
    table_ready = 1'b0;
    table_wr_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_lkup_ap_vld", ACW'(lkup_ap_vld), '0);
    chk("rst_lkup_ap", ACW'(lkup_ap), '0);
    chk("rst_resp_vld", ACW'(resp_vld), '0);
    chk("rst_resp_action", resp_action, '0);
    chk("rst_err", ACW'(err_unexpected), '0);
    req_vld = 4'hF;
    inj_act = act_of(16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      inj_vld = (i == 4);
      tick;
      chk("init_rdy", ACW'(rdy_s), '0);
      chk("init_lkup_vld", ACW'(lkup_ap_vld), '0);
    end
    inj_vld = 1'b0;
    chk("init_no_err", ACW'(err_unexpected), '0);
    table_ready = 1'b1;
    tick;
    chk("run_entry_rdy", ACW'(rdy_s), '0);
    for (int g = 0; g < 5; g++) begin
      tick;
      chk("rr_grant", ACW'(rdy_s), ACW'(4'(1) << gs[g]));
      chk("lkup_vld", ACW'(lkup_ap_vld), ACW'(1));
      chk("lkup_ap", ACW'(lkup_ap), ACW'(16'h10 + gs[g]));
    end
    req_vld = '0;
    tick;
    chk("lkup_vld_drop", ACW'(lkup_ap_vld), '0);
    repeat (5) tick;
    chk("drain_rr", ACW'(exp_q.size()), '0);
    table_en = 1'b0;
    lat_on = 1'b0;
    xfers = 0;
    req_vld = 4'b0100;
    repeat (8) tick;
    chk("full_xfers", ACW'(xfers), ACW'(4));
    chk("full_rdy", ACW'(rdy_s), '0);
    inj_act = act_of(16'h12);
    inj_vld = 1'b1;
    tick;
    chk("full_rdy_pop_cycle", ACW'(rdy_s), '0);
    inj_vld = 1'b0;
    tick;
    chk("rdy_after_pop", ACW'(rdy_s), ACW'(4'b0100));
    req_vld = '0;
    inj_vld = 1'b1;
    repeat (4) tick;
    inj_vld = 1'b0;
    repeat (4) tick;
    chk("drain_full", ACW'(exp_q.size()), '0);
    chk("full_no_err", ACW'(err_unexpected), '0);
    table_en = 1'b1;
    lat_on = 1'b1;
    req_vld = 4'b0011;
    tick;
    chk("pre_busy_grant0", ACW'(rdy_s), ACW'(4'b0001));
    tick;
    chk("pre_busy_grant1", ACW'(rdy_s), ACW'(4'b0010));
    table_wr_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("busy_rdy", ACW'(rdy_s), '0);
    end
    table_wr_busy = 1'b0;
    tick;
    chk("busy_fall_rdy", ACW'(rdy_s), '0);
    tick;
    chk("resume_grant", ACW'(rdy_s), ACW'(4'b0001));
    req_vld = '0;
    repeat (5) tick;
    chk("drain_hold", ACW'(exp_q.size()), '0);
    inj_act = act_of(16'h7777);
    inj_vld = 1'b1;
    tick;
    inj_vld = 1'b0;
    tick;
    chk("err_set", ACW'(err_unexpected), ACW'(1));
    repeat (5) tick;
    chk("err_sticky", ACW'(err_unexpected), ACW'(1));
    chk("err_no_resp", ACW'(resp_vld), '0);
    table_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("err_cleared", ACW'(err_unexpected), '0);
    req_vld = 4'hF;
    tick;
    chk("post_rst_init_rdy", ACW'(rdy_s), '0);
    table_ready = 1'b1;
    req_vld = 4'b0001;
    tick;
    tick;
    chk("post_rst_grant", ACW'(rdy_s), ACW'(4'b0001));
    req_vld = '0;
    table_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_q.delete();
    repeat (4) tick;
    chk("late_result_no_err", ACW'(err_unexpected), '0);
    chk("late_result_no_lkup", ACW'(lkup_ap_vld), '0);
`ifdef AP_ARB_GRANT_CNT_EN
    chk("cnt_reset", ACW'(grant_cnt), '0);
    table_ready = 1'b1;
    req_vld = 4'b0010;
    repeat (70002) tick;
    req_vld = '0;
    repeat (5) tick;
    chk("cnt_saturate", ACW'(grant_cnt[31:16]), ACW'(16'hFFFF));
    chk("cnt_other", ACW'(grant_cnt[15:0]), '0);
`endif
    chk("final_drain", ACW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ap_lookup_arbiter.md
AP_LOOKUP_ARBITER -- requirements
Module: ap_lookup_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of lookup requesters (2..8).
REQ-002 SHALL have parameter AP_WIDTH, default 16, action-pointer width.
REQ-003 SHALL have parameter ACTION_WIDTH, default 160, action word width.
REQ-004 SHALL have parameter ID_FIFO_DEPTH, default 4, maximum outstanding lookups (power of 2).
REQ-005 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_ap  input  NUM_REQ*AP_WIDTH  per-requester AP, requester i at [i*AP_WIDTH +: AP_WIDTH].
REQ-008 SHALL have port req_vld  input  NUM_REQ  per-requester lookup request.
REQ-009 SHALL have port req_rdy  output  NUM_REQ  one-hot grant, combinational; transfer when req_vld[i] & req_rdy[i].
REQ-010 SHALL have port lkup_ap  output  AP_WIDTH  AP driven to the lookup table, registered.
REQ-011 SHALL have port lkup_ap_vld  output  1  lookup strobe to the table, registered.
REQ-012 SHALL have port lkup_action  input  ACTION_WIDTH  action returned by the table.
REQ-013 SHALL have port lkup_action_vld  input  1  table result strobe.
REQ-014 SHALL have port table_ready  input  1  table finished its init sweep.
REQ-015 SHALL have port table_wr_busy  input  1  register-side table write in progress.
REQ-016 SHALL have port resp_action  output  ACTION_WIDTH  returned action, shared by all requesters, registered.
REQ-017 SHALL have port resp_vld  output  NUM_REQ  one-hot result strobe to the owning requester, registered.
REQ-018 SHALL have port err_unexpected  output  1  sticky: result arrived with no lookup outstanding.

Function
REQ-019 SHALL implement FSM INIT -> RUN (table_ready=1); RUN -> HOLD (table_wr_busy=1); HOLD -> RUN (table_wr_busy=0); INIT only on reset.
REQ-020 SHALL assert req_rdy only in RUN, with table_wr_busy=0 and the ID FIFO not full; at most one bit set.
REQ-021 SHALL select round-robin: first i with req_vld[i] searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-022 SHALL set rr_ptr to (winner+1) mod NUM_REQ on each transfer; unchanged otherwise.
REQ-023 SHALL, on transfer, drive lkup_ap=winner AP and lkup_ap_vld=1 next cycle, and push the winner ID into the ID FIFO that same cycle.
REQ-024 SHALL pulse lkup_ap_vld for exactly one cycle per transfer; back-to-back transfers give consecutive pulses.
REQ-025 SHALL, on lkup_action_vld with FIFO non-empty, pop the head ID and, next cycle, drive resp_action=lkup_action and resp_vld[ID]=1 for one cycle.
REQ-026 SHALL handle a simultaneous push and pop in one cycle with no change in occupancy.
REQ-027 SHALL, on lkup_action_vld with FIFO empty in RUN/HOLD, set err_unexpected, emit no resp_vld, and leave rr_ptr unchanged.
REQ-028 SHALL ignore lkup_action_vld in INIT, without flagging an error.
REQ-029 SHALL, in HOLD, keep draining outstanding results while making no new grants.
REQ-030 SHALL give a latency of 3 cycles from transfer to resp_vld, with the table answering 1 cycle after lkup_ap_vld.

Reset
REQ-031 SHALL, on reset: state=INIT, rr_ptr=0, ID FIFO empty, lkup_ap=0, lkup_ap_vld=0, resp_action=0, resp_vld=0, err_unexpected=0.
REQ-032 SHALL, on reset mid-operation, drop all outstanding lookups; their late results fall under REQ-028.

Configuration
REQ-033 SHALL, with macro AP_ARB_GRANT_CNT_EN defined, add output grant_cnt (NUM_REQ*16): per-requester 16-bit counters that increment per transfer, saturate at 16'hFFFF, and reset to 0.
REQ-034 SHALL, with AP_ARB_GRANT_CNT_EN undefined, omit the grant_cnt port and its counters; all other behaviour identical.

Verification
REQ-035 SHALL cover: table_ready=0, req_vld=4'b1111 for 10 cycles -> req_rdy=0, lkup_ap_vld=0 throughout.
REQ-036 SHALL cover: RUN, req_vld=4'b1111 held, ap_i=16'h10+i, 1-cycle table -> grants 0,1,2,3,0 on consecutive cycles; resp_vld one-hot in the same order, each 3 cycles after its grant.
REQ-037 SHALL cover: table never answers, requester 2 streaming -> exactly 4 transfers, then req_rdy=0 until the first lkup_action_vld.
REQ-038 SHALL cover: table_wr_busy=1 for 5 cycles with 2 lookups outstanding -> no new grants, both responses delivered, grants resume the cycle after busy falls.
REQ-039 SHALL cover: lkup_action_vld pulse with FIFO empty in RUN -> err_unexpected=1 and held until reset; resp_vld stays 0.
REQ-040 SHALL cover: with AP_ARB_GRANT_CNT_EN, 70000 grants to requester 1 -> grant_cnt[1]=16'hFFFF.
